// File: rtl/axis_loader_pkg.sv
// Shared definitions for the AXI-Stream to BRAM loader.
// Holds the FSM state encoding and default widths/limits.
package axis_loader_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_MAX_WORDS  = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/axis_bram_loader.sv
// Loads one length-prefixed AXI-Stream packet into BRAM.
// Header word gives payload length; payload written from base_addr.
module axis_bram_loader
    import axis_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_WORDS  = DEF_MAX_WORDS
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int CW = ADDR_WIDTH + 1;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] base;
    logic [CW-1:0]         len;
    logic [CW-1:0]         cnt;
    logic                  err;
    logic                  hs;
    logic                  hdr_bad;
    logic                  last_word;
    logic                  set_err;
    logic                  wr;
    logic                  go;

    assign hs        = s_axis_tvalid && s_axis_tready;
    assign hdr_bad   = (s_axis_tdata == '0) ||
                       (s_axis_tdata > DATA_WIDTH'(MAX_WORDS));
    assign last_word = (cnt == len - CW'(1));
    assign go        = (state == ST_IDLE) && start;

    assign s_axis_tready = (state == ST_HEADER) ||
                           (state == ST_PAYLOAD) ||
                           (state == ST_DRAIN);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign err_len    = err;
    assign word_count = cnt;

    // State register; reset aborts any load in progress.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next-state decode plus write and error strobes.
    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        wr       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_HEADER;
            end
            ST_HEADER: begin
                if (hs) begin
                    if (hdr_bad) begin
                        set_err  = 1'b1;
                        state_nx = s_axis_tlast ? ST_DONE : ST_DRAIN;
                    end else if (s_axis_tlast) begin
                        set_err  = 1'b1;
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    wr = 1'b1;
                    if (s_axis_tlast) begin
                        set_err  = !last_word;
                        state_nx = ST_DONE;
                    end else if (last_word) begin
                        set_err  = 1'b1;
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && s_axis_tlast) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch base/length, register BRAM writes, count words.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            base       <= '0;
            len        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            bram_en <= wr;
            bram_we <= wr;
            if (wr) begin
                bram_addr  <= base + cnt[ADDR_WIDTH-1:0];
                bram_wdata <= s_axis_tdata;
            end
            if (go) begin
                base <= base_addr;
                cnt  <= '0;
                err  <= 1'b0;
            end else begin
                if (wr)      cnt <= cnt + CW'(1);
                if (set_err) err <= 1'b1;
            end
            if (state == ST_HEADER && hs) len <= CW'(s_axis_tdata);
        end
    end

endmodule

// File: tb/tb_axis_bram_loader.sv
// Self-checking bench for axis_bram_loader.
// Packet-level reference model predicts writes, err_len and word_count.
module tb_axis_bram_loader;

    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int MAX = 512;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          busy;
    logic          done;
    logic          err_len;
    logic [AW:0]   word_count;

    axis_bram_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WORDS (MAX)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .start        (start),
        .base_addr    (base_addr),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .busy         (busy),
        .done         (done),
        .err_len      (err_len),
        .word_count   (word_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit e;
        int wc;
    } res_t;

    wr_t           wq[$];
    res_t          dq[$];
    logic [DW-1:0] pkt[$];
    logic [DW-1:0] img[0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Packet-level model: what the loader must write for pkt at base.
    task automatic model(input logic [AW-1:0] base, output int nw,
                         output bit e);
        int L;
        int m;
        L = int'(pkt[0]);
        m = pkt.size() - 1;
        if (L == 0 || L > MAX || m == 0) begin
            nw = 0;
            e  = 1'b1;
        end else begin
            nw = (m < L) ? m : L;
            e  = (m != L);
        end
        for (int i = 0; i < nw; i++)
            wq.push_back('{addr: AW'(int'(base) + i), data: pkt[i+1]});
        dq.push_back('{e: e, wc: nw});
    endtask

    // Monitor: every write and every done pulse is checked here.
    initial begin
        wr_t  w;
        res_t r;
        forever begin
            @(negedge aclk);
            #1;
            if (bram_en || bram_we) begin
                check("we_eq_en", 32'(bram_we), 32'(bram_en));
                if (wq.size() == 0) begin
                    check("unexpected_write", 32'(bram_addr), 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    check("waddr", 32'(bram_addr), 32'(w.addr));
                    check("wdata", 32'(bram_wdata), 32'(w.data));
                end
                img[bram_addr] = bram_wdata;
            end
            if (done) begin
                check("done_busy", 32'(busy), 32'd1);
                if (dq.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    r = dq.pop_front();
                    check("done_err", 32'(err_len), 32'(r.e));
                    check("done_wc", 32'(word_count), 32'(r.wc));
                    check("done_wq_empty", 32'(wq.size()), 32'd0);
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic l,
                             input bit gaps, input bit junk,
                             output int waits);
        waits = 0;
        forever begin
            @(negedge aclk);
            waits++;
            s_axis_tdata  = d;
            s_axis_tlast  = l;
            s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start         = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            base_addr     = junk ? AW'($urandom) : base_addr;
            if (s_axis_tvalid && s_axis_tready) break;
            if (waits > 200) begin
                check("word_timeout", 32'(waits), 32'd0);
                break;
            end
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b0;
            start         = 1'b0;
            #1;
            if (!busy) break;
        end
        if (k == 40) check("idle_timeout", 32'(busy), 32'd0);
        @(negedge aclk);
        start     = 1'b1;
        base_addr = base;
    endtask

    task automatic run_pkt(input logic [AW-1:0] base, input bit gaps,
                           input bit junk, output int nw, output bit e);
        int  total;
        int  w;
        int  dw;
        bit  got;
        model(base, nw, e);
        do_start(base);
        total = 0;
        for (int i = 0; i < pkt.size(); i++) begin
            send_word(pkt[i], (i == pkt.size() - 1), gaps, junk, w);
            total += w;
        end
        dw  = 0;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b0;
            start         = 1'b0;
            #1;
            dw++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (!gaps)
            check("throughput", 32'(total + dw), 32'(pkt.size() + 1));
        @(negedge aclk);
        #1;
        check("hold_err", 32'(err_len), 32'(e));
        check("hold_wc", 32'(word_count), 32'(nw));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tready", 32'(s_axis_tready), 32'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({s_axis_tready, bram_en, bram_we, bram_addr,
                    bram_wdata, busy, done, err_len, word_count});
    endfunction

    initial begin
        int            nw;
        bit            e;
        int            w;
        int            L;
        int            m;
        logic [AW-1:0] b;

        aresetn       = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #3;
        check("reset_outs", 32'(all_outs()), 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        pkt = '{16'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        run_pkt(10'h010, 1'b0, 1'b0, nw, e);
        check("m40_nw", 32'(nw), 32'd3);
        check("m40_err", 32'(e), 32'd0);
        check("img_010", 32'(img[10'h010]), 32'hAAAA);
        check("img_011", 32'(img[10'h011]), 32'hBBBB);
        check("img_012", 32'(img[10'h012]), 32'hCCCC);

        pkt = '{16'd0};
        run_pkt(10'h020, 1'b0, 1'b0, nw, e);
        check("m41_nw", 32'(nw), 32'd0);
        check("m41_err", 32'(e), 32'd1);

        pkt = '{16'd4, 16'h1111, 16'h2222};
        run_pkt(10'h030, 1'b0, 1'b0, nw, e);
        check("m42_nw", 32'(nw), 32'd2);
        check("m42_err", 32'(e), 32'd1);

        pkt = '{16'd2, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        run_pkt(10'h040, 1'b0, 1'b0, nw, e);
        check("m43_nw", 32'(nw), 32'd2);
        check("m43_err", 32'(e), 32'd1);
        check("img_042_untouched", 32'(img[10'h042]), 32'(img[10'h042]) ^ 32'h0 ^
              ((img[10'h042] === 16'h5555) ? 32'h1 : 32'h0));

        pkt = '{16'd4, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        run_pkt(10'h3FE, 1'b0, 1'b0, nw, e);
        check("img_3fe", 32'(img[10'h3FE]), 32'h0A0A);
        check("img_000", 32'(img[10'h000]), 32'h0C0C);
        pkt = '{16'd4, 16'h1A1A, 16'h1B1B, 16'h1C1C, 16'h1D1D};
        run_pkt(10'h3FE, 1'b1, 1'b1, nw, e);
        check("img_3ff", 32'(img[10'h3FF]), 32'h1B1B);
        check("img_001", 32'(img[10'h001]), 32'h1D1D);

        pkt = '{16'd5};
        run_pkt(10'h050, 1'b0, 1'b0, nw, e);
        check("hdr_tlast_err", 32'(e), 32'd1);

        pkt = '{16'd513, 16'h7777, 16'h8888};
        run_pkt(10'h060, 1'b0, 1'b0, nw, e);
        check("too_long_nw", 32'(nw), 32'd0);

        pkt = '{16'd512};
        for (int i = 0; i < 512; i++) pkt.push_back(DW'(i * 3 + 1));
        run_pkt(10'h100, 1'b0, 1'b0, nw, e);
        check("max_len_err", 32'(e), 32'd0);
        check("max_len_nw", 32'(nw), 32'd512);

        // Reset in the middle of a load.
        pkt = '{16'd6, 16'h9001, 16'h9002, 16'h9003};
        do_start(10'h200);
        wq.push_back('{addr: 10'h200, data: 16'h9001});
        wq.push_back('{addr: 10'h201, data: 16'h9002});
        for (int i = 0; i < 3; i++)
            send_word(pkt[i], 1'b0, 1'b0, 1'b0, w);
        @(negedge aclk);
        s_axis_tdata = pkt[3];
        #3;
        aresetn = 1'b0;
        #1;
        check("midrst_outs", 32'(all_outs()), 32'd0);
        check("midrst_wq", 32'(wq.size()), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        check("postrst_idle", 32'(all_outs()), 32'd0);
        s_axis_tvalid = 1'b0;
        pkt = '{16'd2, 16'hBEEF, 16'hCAFE};
        run_pkt(10'h200, 1'b0, 1'b0, nw, e);
        check("postrst_img", 32'(img[10'h201]), 32'hCAFE);

        for (int t = 0; t < 40; t++) begin
            m = $urandom_range(0, 9);
            if (m == 0)      L = 0;
            else if (m == 1) L = 513 + $urandom_range(0, 1000);
            else             L = $urandom_range(1, 8);
            if (L >= 1 && L <= 8) begin
                m = L + $urandom_range(0, 4) - 2;
                if (m < 0) m = 0;
            end else begin
                m = $urandom_range(0, 3);
            end
            pkt = '{DW'(L)};
            for (int i = 0; i < m; i++) pkt.push_back(DW'($urandom));
            b = AW'($urandom);
            run_pkt(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    nw, e);
        end

        check("final_wq", 32'(wq.size()), 32'd0);
        check("final_dq", 32'(dq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
